// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register.
// The state value doubles as the occupancy count.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Handshake FSM for the two-entry skid stage: fire logic, flush priority
// and the load/select enables for the main and skid entries.
module pipe_skid_ctrl
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       arst_n,
   input  logic       flush,
   input  logic       in_valid,
   input  logic       out_ready,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] occupancy,
   output logic       m_load,
   output logic       m_from_skid,
   output logic       s_load,
   output logic       ctrl_clr
);

   state_t state, state_nxt;
   logic   in_fire, out_fire;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake signals decode straight from the state register, so in_ready
   // never depends combinationally on out_ready or flush.
   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign occupancy = state;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign ctrl_clr  = flush;

   always_comb begin
      state_nxt   = state;
      m_load      = 1'b0;
      m_from_skid = 1'b0;
      s_load      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt = ST_ONE;
                  m_load    = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  m_load = 1'b1;
               end else if (in_fire) begin
                  state_nxt = ST_FULL;
                  s_load    = 1'b1;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_nxt   = ST_ONE;
                  m_load      = 1'b1;
                  m_from_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/reg_arstn_en.sv
// Enabled register with asynchronous active-low reset to a fixed value.
module reg_arstn_en #(
   parameter int            W       = 8,
   parameter logic [W-1:0]  RST_VAL = '0
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage register: payload plus control field through a
// valid/ready skid buffer, with flush-to-bubble and a saturating stall counter.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                 DATA_W     = 64,
   parameter int                 CTRL_W     = 8,
   parameter logic [DATA_W-1:0]  PRESET_VAL = '0,
   parameter int                 CNT_W      = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              m_load, m_from_skid, s_load, ctrl_clr;
   logic [DATA_W-1:0] m_data, s_data, m_data_d;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d, s_ctrl_d;

   pipe_skid_ctrl u_ctrl (
      .clk         (clk),
      .arst_n      (arst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .out_ready   (out_ready),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .occupancy   (occupancy),
      .m_load      (m_load),
      .m_from_skid (m_from_skid),
      .s_load      (s_load),
      .ctrl_clr    (ctrl_clr)
   );

   // Flush clears only the control fields; payload is left as-is since a
   // bubble is identified by out_valid and zero control.
   assign m_data_d = m_from_skid ? s_data : in_data;
   assign m_ctrl_d = ctrl_clr ? '0 : (m_from_skid ? s_ctrl : in_ctrl);
   assign s_ctrl_d = ctrl_clr ? '0 : in_ctrl;

   reg_arstn_en #(.W(DATA_W), .RST_VAL(PRESET_VAL)) u_m_data (
      .clk (clk), .arst_n (arst_n), .en (m_load), .d (m_data_d), .q (m_data)
   );

   reg_arstn_en #(.W(CTRL_W), .RST_VAL('0)) u_m_ctrl (
      .clk (clk), .arst_n (arst_n), .en (m_load | ctrl_clr), .d (m_ctrl_d), .q (m_ctrl)
   );

   reg_arstn_en #(.W(DATA_W), .RST_VAL(PRESET_VAL)) u_s_data (
      .clk (clk), .arst_n (arst_n), .en (s_load), .d (in_data), .q (s_data)
   );

   reg_arstn_en #(.W(CTRL_W), .RST_VAL('0)) u_s_ctrl (
      .clk (clk), .arst_n (arst_n), .en (s_load | ctrl_clr), .d (s_ctrl_d), .q (s_ctrl)
   );

   assign out_data = m_data;
   assign out_ctrl = out_valid ? m_ctrl : '0;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: a queue-based model of the stage is
// compared every cycle, with literal expectations pinning key points.
module tb_pipe_skid_stage;

   localparam int DW = 16;
   localparam int CW = 8;
   localparam int NW = 4;
   localparam logic [DW-1:0] PV = 16'hA5A5;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic [NW-1:0] stall_cnt;
   logic          stall_clr = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } beat_t;

   beat_t mq[$];
   int    m_stall = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .PRESET_VAL(PV), .CNT_W(NW)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt),
      .stall_clr (stall_clr)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model advances on the same edge as the DUT.
   task automatic step(input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                       input logic ordy, input logic fl, input logic clr);
      int  cnt;
      bit  acc, pop;
      in_valid  = iv;
      in_data   = id;
      in_ctrl   = ic;
      out_ready = ordy;
      flush     = fl;
      stall_clr = clr;
      @(posedge clk);
      if (arst_n) begin
         cnt = mq.size();
         acc = iv && (cnt < 2);
         pop = (cnt > 0) && ordy;
         if (clr) m_stall = 0;
         else if (cnt > 0 && !ordy && m_stall < (1 << NW) - 1) m_stall++;
         if (fl) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back('{d: id, c: ic});
         end
      end
      #1;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, '0, ordy, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (mq.size() > 0) begin
         chk("out_data", 64'(out_data), 64'(mq[0].d));
         chk("out_ctrl", 64'(out_ctrl), 64'(mq[0].c));
      end else begin
         chk("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
      end
   end

   initial begin
      // reset
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;
      chk("rst_out_data", 64'(out_data), 64'hA5A5);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_occ", 64'(occupancy), 64'd0);

      // streaming
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0);
         chk("stream_data", 64'(out_data), 64'(i));
         chk("stream_occ", 64'(occupancy), 64'd1);
      end
      idle(1'b1);
      chk("stream_drain_occ", 64'(occupancy), 64'd0);
      chk("stream_stall", 64'(stall_cnt), 64'd0);

      // stall
      step(1'b1, 16'h000A, 8'h01, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h000B, 8'h02, 1'b0, 1'b0, 1'b0);
      chk("stall_occ2", 64'(occupancy), 64'd2);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      idle(1'b0);
      chk("stall_head_a", 64'(out_data), 64'h000A);
      idle(1'b1);
      chk("stall_head_b", 64'(out_data), 64'h000B);
      idle(1'b1);
      chk("stall_empty", 64'(occupancy), 64'd0);
      chk("stall_count", 64'(stall_cnt), 64'd2);

      // flush when full, control 0xFF in both entries
      step(1'b1, 16'h0011, 8'hFF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h0022, 8'hFF, 1'b0, 1'b0, 1'b0);
      chk("flush_pre_occ", 64'(occupancy), 64'd2);
      step(1'b1, 16'h0033, 8'hFF, 1'b0, 1'b1, 1'b0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_ctrl", 64'(out_ctrl), 64'd0);
      chk("flush_occ", 64'(occupancy), 64'd0);
      step(1'b1, 16'h0044, 8'hFF, 1'b1, 1'b1, 1'b0);
      chk("flush_drop_in", 64'(out_valid), 64'd0);
      idle(1'b1);

      // flush together with an output handshake
      step(1'b1, 16'h0055, 8'h05, 1'b1, 1'b0, 1'b0);
      chk("fo_head", 64'(out_data), 64'h0055);
      step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      chk("fo_occ", 64'(occupancy), 64'd0);
      idle(1'b1);

      // counter saturation
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      chk("sat_clr", 64'(stall_cnt), 64'd0);
      step(1'b1, 16'h0066, 8'h06, 1'b1, 1'b0, 1'b0);
      repeat (20) idle(1'b0);
      chk("sat_15", 64'(stall_cnt), 64'd15);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk("sat_clr_wins", 64'(stall_cnt), 64'd0);
      idle(1'b1);

      // asynchronous reset while full
      step(1'b1, 16'h0077, 8'h07, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h0088, 8'h08, 1'b0, 1'b0, 1'b0);
      chk("ar_full", 64'(occupancy), 64'd2);
      #1 arst_n = 1'b0;
      mq.delete();
      m_stall = 0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_occ", 64'(occupancy), 64'd0);
      chk("ar_in_ready", 64'(in_ready), 64'd1);
      chk("ar_data", 64'(out_data), 64'hA5A5);
      chk("ar_stall", 64'(stall_cnt), 64'd0);
      step(1'b1, 16'h0099, 8'h09, 1'b1, 1'b0, 1'b0);
      arst_n = 1'b1;
      chk("ar_rel_ready", 64'(in_ready), 64'd1);
      step(1'b1, 16'h00AB, 8'h03, 1'b1, 1'b0, 1'b0);
      chk("ar_first_valid", 64'(out_valid), 64'd1);
      chk("ar_first_data", 64'(out_data), 64'h00AB);
      chk("ar_first_ctrl", 64'(out_ctrl), 64'h03);
      idle(1'b1);
      idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline-stage register for the pipelined core, generalising the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It carries an arbitrary data payload plus a separately handled control field through a valid/ready handshake, using a two-entry skid buffer so `in_ready` is purely registered. It adds synchronous flush (bubble insertion) and a saturating stall counter. Stage registers between any two pipeline stages are instances of this block.

## Interface
- `DATA_W`, default 64: payload width (operands, PC, immediate, register indices, concatenated).
- `CTRL_W`, default 8: control-field width (writeback, memwrite, memread, branch, alusrc, aluop…); zeroed on bubbles.
- `PRESET_VAL`, default 0: reset value of the payload registers.
- `CNT_W`, default 16: stall counter width.
- `clk` in 1: clock.
- `arst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous flush of all held entries.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage can accept a beat; registered.
- `in_data` in DATA_W: upstream payload.
- `in_ctrl` in CTRL_W: upstream control field.
- `out_valid` out 1: downstream beat valid.
- `out_ready` in 1: downstream accepts; low = stall.
- `out_data` out DATA_W: head payload.
- `out_ctrl` out CTRL_W: head control, forced 0 when `out_valid`=0.
- `occupancy` out 2: entries held, 0..2.
- `stall_cnt` out CNT_W: cycles with `out_valid & !out_ready`, saturating.
- `stall_clr` in 1: synchronous clear of `stall_cnt`.

## Operation
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: main entry (`m_data`, `m_ctrl`) drives the outputs; skid entry (`s_data`, `s_ctrl`) is used only when a beat arrives while downstream stalls.
- FSM states:
  - **EMPTY** (occ 0): `in_fire` → ONE, main ← in.
  - **ONE** (occ 1), `in_fire & out_fire` → ONE, main ← in.
  - **ONE**, `in_fire & !out_ready` → FULL, skid ← in.
  - **ONE**, `!in_fire & out_fire` → EMPTY.
  - **FULL** (occ 2): `out_fire` → ONE, main ← skid.
- `in_ready = (state != FULL)`; `out_valid = (state != EMPTY)`; `occupancy` encodes the state.
- `flush` has highest priority. Next state is EMPTY, and `m_ctrl`/`s_ctrl` are cleared to 0. Data registers are not cleared. A beat accepted in the flush cycle (`in_ready`=1) is consumed and discarded.
- `out_ctrl = out_valid ? m_ctrl : 0`. Downstream never sees stale control on a bubble.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by `flush`.
- `stall_cnt`:
  - +1 per cycle with `out_valid & !out_ready`; saturates at 2^CNT_W−1.
  - `stall_clr` forces 0 and wins over increment.
  - `flush` does not clear it.

## Timing
- Reset (`arst_n`=0, asynchronous) sets:
  - state EMPTY;
  - `m_data`/`s_data` to PRESET_VAL and ctrl registers to 0;
  - `stall_cnt`=0;
  - outputs `out_valid`=0, `out_ctrl`=0, `out_data`=PRESET_VAL, `occupancy`=0, `in_ready`=1.
- Inputs are ignored while `arst_n`=0. Reset mid-operation discards all held beats immediately.
- Latency is 1 cycle: a beat accepted at edge N is on `out_*` after edge N, if the stage was EMPTY or the ONE entry fires at N.
- Throughput is 1 beat/cycle when `out_ready` is held high.
- `in_ready` has no combinational path from `out_ready` or `flush`. All outputs are register-driven except `out_ctrl`, which is gated by `out_valid`.
- Stall of 1 cycle: at most one beat lands in skid; `in_ready` drops the cycle after.

## Structure
- Package `pipe_pkg` holds the state encodings: `ST_EMPTY`=2'd0, `ST_ONE`=2'd1, `ST_FULL`=2'd2.
- Sub-module `pipe_skid_ctrl` contains the FSM, the fire logic, the flush priority and the load/select enables for main and skid.
- Payload and control registers are `reg_arstn_en` instances driven by those enables.
- The stall counter lives in the top module.

## Test plan
- **Streaming.** Reset, then stream 0x1..0x8 with `in_valid`=`out_ready`=1.
  - Expect outputs 0x1..0x8 one cycle after input, back-to-back.
  - `occupancy` stays 1 and `stall_cnt` stays 0.
- **Stall.** Accept 0xA, hold `out_ready`=0, present 0xB.
  - 0xB is accepted, `occupancy`=2, `in_ready`=0 next cycle.
  - Release `out_ready`: expect 0xA, then 0xB, then `occupancy`=0. `stall_cnt` equals the stall cycles.
- **Flush when FULL.** Flush with ctrl 0xFF in both entries.
  - Next cycle: `out_valid`=0, `out_ctrl`=0x00, `occupancy`=0.
  - The beat presented during flush never appears.
- **Flush with simultaneous output.** Flush together with `out_fire` in state ONE: the output beat is consumed once and the stage is EMPTY afterwards.
- **Counter saturation.** With CNT_W=4 and a 20-cycle stall, `stall_cnt` saturates at 15. `stall_clr` with a stall in the same cycle gives 0.
- **Asynchronous reset.** Assert `arst_n` low mid-stream while FULL.
  - Outputs reset immediately without a clock edge.
  - After release, `in_ready`=1 and the first new beat appears 1 cycle after acceptance.
